// File: rtl/nvdla_mcif_pkg.sv
// Shared MCIF write-path types and constants.
// Used by the outstanding-write limiter, its credit counter and the bench.
package nvdla_mcif_pkg;

    localparam int ADDR_W            = 64;
    localparam int ID_W              = 8;
    localparam int CNT_W             = 9;
    localparam int MCIF_WR_MAX_BEATS = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [1:0]        len;
    } mcif_aw_cmd_t;

    // AXI len fields carry beats-1.
    function automatic int unsigned mcif_beats(input logic [1:0] len);
        return int'(len) + 1;
    endfunction

endpackage

// File: rtl/nvdla_mcif_wr_os_credit.sv
// Outstanding-beat counter with credit check, underflow clamp and sticky error.
// Credits are taken at command accept and returned when the egress retires a burst.
module nvdla_mcif_wr_os_credit
    import nvdla_mcif_pkg::*;
#(
    parameter int CNT_W = nvdla_mcif_pkg::CNT_W
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [7:0]       reg2dp_wr_os_cnt,
    input  logic [1:0]       req_len,
    input  logic             accept,
    input  logic             rel_vld,
    input  logic [1:0]       rel_len,
    output logic             credit_ok,
    output logic [CNT_W-1:0] os_cnt,
    output logic             os_err
);

    logic [CNT_W:0] need_w;
    logic [CNT_W:0] limit_w;
    logic [CNT_W:0] cnt_w;
    logic [CNT_W:0] inc_w;
    logic [CNT_W:0] dec_w;
    logic [CNT_W:0] sum_w;

    // One extra bit of headroom so the compare and the net update never wrap.
    assign need_w    = (CNT_W+1)'(mcif_beats(req_len));
    assign limit_w   = (CNT_W+1)'(reg2dp_wr_os_cnt) + (CNT_W+1)'(1);
    assign cnt_w     = {1'b0, os_cnt};
    assign credit_ok = (cnt_w + need_w) <= limit_w;

    assign inc_w = accept  ? need_w : '0;
    assign dec_w = rel_vld ? (CNT_W+1)'(mcif_beats(rel_len)) : '0;
    assign sum_w = cnt_w + inc_w;

    // A release larger than what is outstanding means the egress lost sync;
    // clamp to zero rather than wrap, and latch the error until reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            os_cnt <= '0;
            os_err <= 1'b0;
        end else if (dec_w > sum_w) begin
            os_cnt <= '0;
            os_err <= 1'b1;
        end else begin
            os_cnt <= CNT_W'(sum_w - dec_w);
        end
    end

endmodule

// File: rtl/nvdla_mcif_wr_os_limiter_sva.sv
// Protocol checks bound into the limiter: AW payload hold and counter range.
module nvdla_mcif_wr_os_limiter_sva #(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8,
    parameter int CNT_W  = 9
) (
    input logic              clk,
    input logic              rst,
    input logic              awvalid,
    input logic              awready,
    input logic [ADDR_W-1:0] awaddr,
    input logic [ID_W-1:0]   awid,
    input logic [3:0]        awlen,
    input logic [CNT_W-1:0]  os_cnt_cur
);

    property p_aw_hold;
        @(posedge clk) disable iff (rst)
            (awvalid && !awready) |=>
                (awvalid && $stable(awaddr) && $stable(awid) && $stable(awlen));
    endproperty

    property p_cnt_range;
        @(posedge clk) disable iff (rst)
            ({1'b0, os_cnt_cur} <= (CNT_W+1)'(256));
    endproperty

    a_aw_hold:   assert property (p_aw_hold);
    a_cnt_range: assert property (p_cnt_range);

endmodule

bind nvdla_mcif_wr_os_limiter nvdla_mcif_wr_os_limiter_sva #(
    .ADDR_W(ADDR_W),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
) u_sva (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .awvalid   (mcif2noc_axi_aw_awvalid),
    .awready   (mcif2noc_axi_aw_awready),
    .awaddr    (mcif2noc_axi_aw_awaddr),
    .awid      (mcif2noc_axi_aw_awid),
    .awlen     (mcif2noc_axi_aw_awlen),
    .os_cnt_cur(os_cnt_cur)
);

// File: rtl/nvdla_mcif_wr_os_limiter.sv
// Outstanding-write limiter: one-entry AW output stage gated by beat credits.
// A command is accepted when the stage can take it and the beat budget allows.
module nvdla_mcif_wr_os_limiter
    import nvdla_mcif_pkg::*;
#(
    parameter int ADDR_W = nvdla_mcif_pkg::ADDR_W,
    parameter int ID_W   = nvdla_mcif_pkg::ID_W,
    parameter int CNT_W  = nvdla_mcif_pkg::CNT_W
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic [7:0]        reg2dp_wr_os_cnt,
    input  logic              in_aw_valid,
    output logic              in_aw_ready,
    input  logic [ADDR_W-1:0] in_aw_addr,
    input  logic [ID_W-1:0]   in_aw_id,
    input  logic [1:0]        in_aw_len,
    output logic              mcif2noc_axi_aw_awvalid,
    input  logic              mcif2noc_axi_aw_awready,
    output logic [ADDR_W-1:0] mcif2noc_axi_aw_awaddr,
    output logic [ID_W-1:0]   mcif2noc_axi_aw_awid,
    output logic [3:0]        mcif2noc_axi_aw_awlen,
    input  logic              eg2ig_axi_vld,
    input  logic [1:0]        eg2ig_axi_len,
    output logic [CNT_W-1:0]  os_cnt_cur,
    output logic              os_stall,
    output logic              os_err
);

    logic              credit_ok;
    logic              slot_free;
    logic              accept;
    logic              full;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [1:0]        aw_len_q;

    // Ready is a function of state and the presented length only, never of valid.
    assign slot_free   = !full || mcif2noc_axi_aw_awready;
    assign in_aw_ready = slot_free && credit_ok;
    assign accept      = in_aw_valid && in_aw_ready;
    assign os_stall    = in_aw_valid && slot_free && !credit_ok;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            full      <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_len_q  <= '0;
        end else if (accept) begin
            full      <= 1'b1;
            aw_addr_q <= in_aw_addr;
            aw_id_q   <= in_aw_id;
            aw_len_q  <= in_aw_len;
        end else if (mcif2noc_axi_aw_awready) begin
            full      <= 1'b0;
        end
    end

    assign mcif2noc_axi_aw_awvalid = full;
    assign mcif2noc_axi_aw_awaddr  = aw_addr_q;
    assign mcif2noc_axi_aw_awid    = aw_id_q;
    assign mcif2noc_axi_aw_awlen   = {2'b00, aw_len_q};

    nvdla_mcif_wr_os_credit #(
        .CNT_W(CNT_W)
    ) u_credit (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rst  (nvdla_core_rst),
        .reg2dp_wr_os_cnt(reg2dp_wr_os_cnt),
        .req_len         (in_aw_len),
        .accept          (accept),
        .rel_vld         (eg2ig_axi_vld),
        .rel_len         (eg2ig_axi_len),
        .credit_ok       (credit_ok),
        .os_cnt          (os_cnt_cur),
        .os_err          (os_err)
    );

endmodule

// File: tb/tb_nvdla_mcif_wr_os_limiter.sv
// Bench for the outstanding-write limiter: directed cycles with a scoreboard
// of expected AW commands, popped whenever the DUT hands one to the NOC.
module tb_nvdla_mcif_wr_os_limiter;
    import nvdla_mcif_pkg::*;

    localparam int AW = 64;
    localparam int IW = 8;
    localparam int CW = 9;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rst = 1'b1;
    logic [7:0]    reg2dp_wr_os_cnt = 8'd15;
    logic          in_aw_valid = 1'b0;
    logic          in_aw_ready;
    logic [AW-1:0] in_aw_addr = '0;
    logic [IW-1:0] in_aw_id = '0;
    logic [1:0]    in_aw_len = '0;
    logic          mcif2noc_axi_aw_awvalid;
    logic          mcif2noc_axi_aw_awready = 1'b1;
    logic [AW-1:0] mcif2noc_axi_aw_awaddr;
    logic [IW-1:0] mcif2noc_axi_aw_awid;
    logic [3:0]    mcif2noc_axi_aw_awlen;
    logic          eg2ig_axi_vld = 1'b0;
    logic [1:0]    eg2ig_axi_len = '0;
    logic [CW-1:0] os_cnt_cur;
    logic          os_stall;
    logic          os_err;

    int err_cnt = 0;
    int chk_cnt = 0;
    mcif_aw_cmd_t sb_q[$];
    mcif_aw_cmd_t mon_c;

    nvdla_mcif_wr_os_limiter #(
        .ADDR_W(AW),
        .ID_W  (IW),
        .CNT_W (CW)
    ) dut (
        .nvdla_core_clk         (nvdla_core_clk),
        .nvdla_core_rst         (nvdla_core_rst),
        .reg2dp_wr_os_cnt       (reg2dp_wr_os_cnt),
        .in_aw_valid            (in_aw_valid),
        .in_aw_ready            (in_aw_ready),
        .in_aw_addr             (in_aw_addr),
        .in_aw_id               (in_aw_id),
        .in_aw_len              (in_aw_len),
        .mcif2noc_axi_aw_awvalid(mcif2noc_axi_aw_awvalid),
        .mcif2noc_axi_aw_awready(mcif2noc_axi_aw_awready),
        .mcif2noc_axi_aw_awaddr (mcif2noc_axi_aw_awaddr),
        .mcif2noc_axi_aw_awid   (mcif2noc_axi_aw_awid),
        .mcif2noc_axi_aw_awlen  (mcif2noc_axi_aw_awlen),
        .eg2ig_axi_vld          (eg2ig_axi_vld),
        .eg2ig_axi_len          (eg2ig_axi_len),
        .os_cnt_cur             (os_cnt_cur),
        .os_stall               (os_stall),
        .os_err                 (os_err)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, checks ready/stall at the falling edge and
    // records the command if it is expected to be accepted this cycle.
    task automatic applyStimulus(input logic v, input logic [63:0] a,
                                 input logic [7:0] cid, input logic [1:0] len,
                                 input logic ar, input logic rv,
                                 input logic [1:0] rl, input logic exp_rdy,
                                 input logic exp_stall);
        mcif_aw_cmd_t c;
        in_aw_valid             = v;
        in_aw_addr              = a;
        in_aw_id                = cid;
        in_aw_len               = len;
        mcif2noc_axi_aw_awready = ar;
        eg2ig_axi_vld           = rv;
        eg2ig_axi_len           = rl;
        @(negedge nvdla_core_clk);
        checkOutput("in_aw_ready", {63'd0, in_aw_ready}, {63'd0, exp_rdy});
        checkOutput("os_stall", {63'd0, os_stall}, {63'd0, exp_stall});
        if (v && exp_rdy) begin
            c.addr = a;
            c.id   = cid;
            c.len  = len;
            sb_q.push_back(c);
        end
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    // Every AW handshake must match the oldest command the bench expects.
    always @(negedge nvdla_core_clk) begin
        if (!nvdla_core_rst && mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready) begin
            if (sb_q.size() == 0) begin
                checkOutput("aw_unexpected", 64'd1, 64'd0);
            end else begin
                mon_c = sb_q.pop_front();
                checkOutput("awaddr", mcif2noc_axi_aw_awaddr, mon_c.addr);
                checkOutput("awid", {56'd0, mcif2noc_axi_aw_awid}, {56'd0, mon_c.id});
                checkOutput("awlen", {60'd0, mcif2noc_axi_aw_awlen}, {62'd0, mon_c.len});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rst = 1'b0;

        // Out of reset: nothing pending, no credits in use.
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("rst_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd0);
        checkOutput("rst_os_cnt", {55'd0, os_cnt_cur}, 64'd0);
        checkOutput("rst_os_err", {63'd0, os_err}, 64'd0);
        tick();

        // Basic: len=3 with limit 16.
        applyStimulus(1, 64'h1000, 8'h01, 2'd3, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("basic_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd1);
        checkOutput("basic_awlen", {60'd0, mcif2noc_axi_aw_awlen}, 64'h3);
        checkOutput("basic_os_cnt", {55'd0, os_cnt_cur}, 64'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd3, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("basic_rel_os_cnt", {55'd0, os_cnt_cur}, 64'd0);
        checkOutput("basic_idle_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd0);
        tick();

        // Limit 8: two len=3 fit, the third waits for a release.
        reg2dp_wr_os_cnt = 8'd7;
        applyStimulus(1, 64'h2000, 8'h02, 2'd3, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(1, 64'h2040, 8'h03, 2'd3, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(1, 64'h2080, 8'h04, 2'd3, 1, 0, 0, 0, 1);
        checkOutput("limit_os_cnt_full", {55'd0, os_cnt_cur}, 64'd8);
        tick();
        applyStimulus(1, 64'h2080, 8'h04, 2'd3, 1, 1, 2'd3, 0, 1);
        tick();
        applyStimulus(1, 64'h2080, 8'h04, 2'd3, 1, 0, 0, 1, 0);
        checkOutput("limit_os_cnt_rel", {55'd0, os_cnt_cur}, 64'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("limit_os_cnt_again", {55'd0, os_cnt_cur}, 64'd8);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd1, 0, 0);
        tick();

        // Simultaneous accept (+2) and release (-4) from 6.
        applyStimulus(1, 64'h3000, 8'h05, 2'd1, 1, 1, 2'd3, 1, 0);
        checkOutput("simul_os_cnt_before", {55'd0, os_cnt_cur}, 64'd6);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("simul_os_cnt_after", {55'd0, os_cnt_cur}, 64'd4);
        tick();

        // Underflow: release 4 beats while only 2 are outstanding.
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd3, 1, 0);
        checkOutput("uflow_os_cnt_before", {55'd0, os_cnt_cur}, 64'd2);
        checkOutput("uflow_os_err_before", {63'd0, os_err}, 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("uflow_os_cnt", {55'd0, os_cnt_cur}, 64'd0);
        checkOutput("uflow_os_err", {63'd0, os_err}, 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("uflow_os_err_sticky", {63'd0, os_err}, 64'd1);
        tick();

        // Backpressure: awready low for 5 cycles of back-to-back valid.
        reg2dp_wr_os_cnt = 8'd15;
        applyStimulus(1, 64'h4000, 8'h06, 2'd0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 64'h4100, 8'h07, 2'd1, 0, 0, 0, 0, 0);
            checkOutput("bp_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd1);
            checkOutput("bp_awaddr", mcif2noc_axi_aw_awaddr, 64'h4000);
            checkOutput("bp_awid", {56'd0, mcif2noc_axi_aw_awid}, 64'h06);
            checkOutput("bp_os_cnt", {55'd0, os_cnt_cur}, 64'd1);
            tick();
        end
        applyStimulus(1, 64'h4100, 8'h07, 2'd1, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(1, 64'h4200, 8'h08, 2'd2, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(1, 64'h4300, 8'h09, 2'd3, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("bp_os_cnt_flow", {55'd0, os_cnt_cur}, 64'd10);
        tick();

        // Limit dropped to 4 with 12 outstanding: stall until the count drains.
        applyStimulus(1, 64'h5000, 8'h0a, 2'd1, 1, 0, 0, 1, 0);
        tick();
        reg2dp_wr_os_cnt = 8'd3;
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 0, 0, 0, 1);
        checkOutput("drop_os_cnt_12", {55'd0, os_cnt_cur}, 64'd12);
        tick();
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 1, 2'd3, 0, 1);
        tick();
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 1, 2'd3, 0, 1);
        checkOutput("drop_os_cnt_8", {55'd0, os_cnt_cur}, 64'd8);
        tick();
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 0, 0, 0, 1);
        checkOutput("drop_os_cnt_4", {55'd0, os_cnt_cur}, 64'd4);
        tick();

        // Reset while stalled.
        nvdla_core_rst = 1'b1;
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mrst_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd0);
        checkOutput("mrst_awaddr", mcif2noc_axi_aw_awaddr, 64'd0);
        checkOutput("mrst_awid", {56'd0, mcif2noc_axi_aw_awid}, 64'd0);
        checkOutput("mrst_awlen", {60'd0, mcif2noc_axi_aw_awlen}, 64'd0);
        checkOutput("mrst_os_cnt", {55'd0, os_cnt_cur}, 64'd0);
        checkOutput("mrst_os_err", {63'd0, os_err}, 64'd0);
        tick();
        nvdla_core_rst = 1'b0;

        // Exactly at the limit: 4 beats against limit 4.
        applyStimulus(1, 64'h5100, 8'h0b, 2'd3, 1, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("edge_os_cnt", {55'd0, os_cnt_cur}, 64'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd3, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("end_os_cnt", {55'd0, os_cnt_cur}, 64'd0);
        checkOutput("end_awvalid", {63'd0, mcif2noc_axi_aw_awvalid}, 64'd0);
        tick();

        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
